ac_store_buffer: RTL and testbench
==================================

// Module: ac_store_buffer
// PURPOSE
//  Write-side counterpart of the accumulator load path: takes store requests (AC value + address)
//  from the control unit and drains them to data memory over a we/ack handshake.
//  Holds up to DEPTH stores so the control FSM does not stall on slow memory.
//  Sits between the AC/AR registers and the data-memory write port of the 24-bit matmul core.
// PARAMETERS
//  WORD_SIZE   24  data width; matches the AC width
//  ADDR_WIDTH  16  data-memory address width
//  DEPTH       4   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-low reset
//  st_valid   in   1           store request from control unit
//  st_ready   out  1           buffer can accept; = ~full (combinational from count)
//  st_data    in   WORD_SIZE   value to store (AC data_out)
//  st_addr    in   ADDR_WIDTH  target address (AR)
//  mem_we     out  1           write strobe to data memory
//  mem_addr   out  ADDR_WIDTH  write address; stable while mem_we=1
//  mem_data   out  WORD_SIZE   write data; stable while mem_we=1
//  mem_ack    in   1           memory accepted the write this cycle
//  empty      out  1           no stores pending and none in flight
//  count      out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low on rst. rst=0 at a rising clk edge:
//   rd/wr pointers=0, count=0, state=IDLE, mem_we=0, mem_addr=0, mem_data=0; empty=1, st_ready=1.
//  Push: st_valid & st_ready at an edge writes {st_addr,st_data} at wr_ptr; wr_ptr+1 (wraps mod DEPTH).
//  Full (count==DEPTH): st_ready=0; a push is refused even if a pop occurs the same edge.
//  FSM (mem_we/mem_addr/mem_data registered):
//   IDLE : count!=0 -> WRITE; load mem_addr/mem_data from head entry; mem_we<=1.
//   WRITE: hold mem_we=1, addr/data unchanged. mem_ack=1 -> pop head (rd_ptr+1), mem_we<=0, ->IDLE.
//  Latency: store accepted at edge E -> mem_we=1 after edge E+1. Max throughput 1 store / 2 cycles
//   (mandatory IDLE cycle between writes). mem_ack ignored while IDLE.
//  Same edge push+pop: count unchanged; both pointers advance.
//  Ordering: strict FIFO; memory sees stores in acceptance order, no merging of equal addresses.
//  empty = (count==0) & (state==IDLE).
//  Reset mid-write: pending and in-flight stores are discarded; mem_we drops at the reset edge.
//  Count never wraps: no push when full, no pop when empty.
// CONFIGURATION
//  STORE_FWD_EN defined: adds ports ld_addr (in, ADDR_WIDTH), fwd_hit (out,1), fwd_data (out,WORD_SIZE).
//   Combinational: fwd_hit=1 if any occupied entry (including the in-flight head) has addr==ld_addr;
//   fwd_data = data of the youngest such entry, else 0. Lets AC loads see unretired stores.
//  Undefined: ports absent; control unit must wait for empty before any load.
// STRUCTURE
//  Shared package: state encoding (IDLE/WRITE), WORD_SIZE/ADDR_WIDTH defaults shared with AC/AR.
//  One sub-module: store_fifo_mem (DEPTH x (ADDR_WIDTH+WORD_SIZE) regfile, 1 write/1 read port).
//  FSM, pointers, count and forwarding compare stay in ac_store_buffer.
// TESTING
//  1 Reset: rst=0 during a WRITE with mem_ack=0 -> next cycle mem_we=0, count=0, empty=1, st_ready=1.
//  2 Single store 0x00ABCD @0x0010, mem_ack on 2nd WRITE cycle -> mem_we high 2 cycles, addr 0x0010,
//    data 0x00ABCD held stable; then empty=1.
//  3 Fill: 5 back-to-back st_valid, mem_ack=0 -> first 4 accepted, st_ready=0 on 5th, count=4.
//  4 Drain with mem_ack tied 1 -> writes 1,2,3,4 in order, one every 2 cycles, mem_we low between.
//  5 Full + ack same edge with st_valid=1 -> push refused, count 4->3; retry accepted next edge.
//  6 STORE_FWD_EN: stores 0x000001@0x20 then 0x000002@0x20, ld_addr=0x20 -> fwd_hit=1,
//    fwd_data=0x000002; ld_addr=0x21 -> fwd_hit=0, fwd_data=0.

Source files
------------

// File: rtl/ac_store_buffer_pkg.sv
// Shared definitions for the accumulator store buffer: default datapath
// widths (shared with the AC/AR registers) and the drain FSM state encoding.
package ac_store_buffer_pkg;

  localparam int WORD_SIZE_DEF  = 24;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 4;

  // Drain FSM: IDLE looks for a pending entry, WRITE holds the strobe until ack.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_t;

endpackage

// File: rtl/ac_store_buffer_if.sv
// Store-request and data-memory write bus of the accumulator store buffer.
//
// Handshakes:
//  - Store side: a store transfers at a rising edge where st_valid & st_ready.
//    st_ready depends only on buffer occupancy, never on st_valid.
//  - Memory side: mem_we rises with mem_addr/mem_data already valid; all three
//    hold until an edge with mem_ack=1, which retires the write. mem_ack is
//    ignored while mem_we=0.
// master = control unit / memory model side, slave = the store buffer.
interface ac_store_buffer_if
  import ac_store_buffer_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  st_valid;
  logic                  st_ready;
  logic [WORD_SIZE-1:0]  st_data;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  mem_ack;

  modport master (
    output st_valid, st_data, st_addr, mem_ack,
    input  st_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  st_valid, st_data, st_addr, mem_ack,
    output st_ready, mem_we, mem_addr, mem_data
  );

endinterface

// File: rtl/ac_store_buffer_store_fifo_mem.sv
// Store FIFO register file: DEPTH entries of {addr, data}, one synchronous
// write port and one combinational read port. With STORE_FWD_EN defined the
// whole array is also exported so the top can run the forwarding compare.
module ac_store_buffer_store_fifo_mem
  import ac_store_buffer_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int W     = ADDR_WIDTH_DEF + WORD_SIZE_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [W-1:0]            wdata,
  input  logic [AW-1:0]           raddr,
  output logic [W-1:0]            rdata
`ifdef STORE_FWD_EN
  ,
  output logic [DEPTH-1:0][W-1:0] entries
`endif
);

  logic [DEPTH-1:0][W-1:0] mem;

  // Entry contents carry no reset: occupancy is tracked by the top's count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef STORE_FWD_EN
  assign entries = mem;
`endif

endmodule

// File: rtl/ac_store_buffer.sv
// Accumulator store buffer: queues {AR, AC} store requests and drains them in
// order to data memory over a we/ack handshake, one write every two cycles.
// Optional feature macro: STORE_FWD_EN adds ld_addr/fwd_hit/fwd_data so AC
// loads can see stores that have not yet retired to memory.
module ac_store_buffer
  import ac_store_buffer_pkg::*;
#(
  parameter  int WORD_SIZE  = WORD_SIZE_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ac_store_buffer_if.slave      bus,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output sb_state_t             dbg_state
`ifdef STORE_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  fwd_hit,
  output logic [WORD_SIZE-1:0]  fwd_data
`endif
);

  localparam int EW = ADDR_WIDTH + WORD_SIZE;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  sb_state_t     state;
  logic          push;
  logic          pop;

  // A full buffer refuses pushes even when the head retires on the same edge.
  assign bus.st_ready = (count != CW'(DEPTH));
  assign push         = bus.st_valid & bus.st_ready;
  assign pop          = (state == WRITE) & bus.mem_ack;
  assign empty        = (count == '0) & (state == IDLE);
  assign dbg_state    = state;

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [PW-1:0]            fwd_idx;
`endif

  ac_store_buffer_store_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_store_fifo_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({bus.st_addr, bus.st_data}),
    .raddr (rd_ptr),
    .rdata (head)
`ifdef STORE_FWD_EN
    ,
    .entries (entries)
`endif
  );

  // Pointers and occupancy: push and pop on the same edge leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Drain FSM with registered write strobe, address and data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state                        <= WRITE;
            bus.mem_we                   <= 1'b1;
            {bus.mem_addr, bus.mem_data} <= head;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            state      <= IDLE;
            bus.mem_we <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_FWD_EN
  // Scan occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (entries[fwd_idx][EW-1 -: ADDR_WIDTH] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[fwd_idx][WORD_SIZE-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ac_store_buffer.sv
// Testbench for ac_store_buffer: directed scenarios plus randomized traffic,
// checked by a negedge monitor against a queue-based model of the buffer.
module tb_ac_store_buffer;
  import ac_store_buffer_pkg::*;

  localparam int WS    = 24;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = AW + WS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ac_store_buffer_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  logic          empty;
  logic [CW-1:0] count;
  sb_state_t     dbg_state;
`ifdef STORE_FWD_EN
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [WS-1:0] fwd_data;
`endif

  ac_store_buffer #(
    .WORD_SIZE  (WS),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .empty     (empty),
    .count     (count),
    .dbg_state (dbg_state)
`ifdef STORE_FWD_EN
    ,
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int  m_count = 0;
  int  n_done  = 0;
  bit  exp_we_next, exp_idle_next, prev_we, prev_done;
  logic [EW-1:0] prev_bus;
  logic [EW-1:0] e;
  bit  accept, done;
`ifdef STORE_FWD_EN
  logic          m_hit;
  logic [WS-1:0] m_fwd;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / model ----------------
  // Model: exp_q holds every occupied entry (in-flight head included) in
  // acceptance order; m_count is the occupancy the DUT should show now.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_count       = 0;
      exp_we_next   = 0;
      exp_idle_next = 0;
      prev_we       = 0;
      prev_done     = 0;
    end else begin
      chk("count", 64'(count), 64'(m_count));
      chk("st_ready", 64'(bus.st_ready), 64'(m_count < DEPTH));
      chk("empty", 64'(empty), 64'(m_count == 0));
      if (exp_idle_next) chk("idle_gap", 64'(bus.mem_we), 64'd0);
      if (exp_we_next)   chk("we_start", 64'(bus.mem_we), 64'd1);
      if (bus.mem_we && prev_we && !prev_done)
        chk("wr_stable", 64'({bus.mem_addr, bus.mem_data}), 64'(prev_bus));
`ifdef STORE_FWD_EN
      m_hit = 1'b0;
      m_fwd = '0;
      foreach (exp_q[k]) begin
        if (exp_q[k][EW-1:WS] == ld_addr) begin
          m_hit = 1'b1;
          m_fwd = exp_q[k][WS-1:0];
        end
      end
      chk("fwd_hit", 64'(fwd_hit), 64'(m_hit));
      chk("fwd_data", 64'(fwd_data), 64'(m_fwd));
`endif
      done = bus.mem_we && bus.mem_ack;
      if (done) begin
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.mem_addr), 64'(e[EW-1:WS]));
          chk("wr_data", 64'(bus.mem_data), 64'(e[WS-1:0]));
          n_done++;
        end
      end
      accept = bus.st_valid && (m_count < DEPTH);
      if (accept) exp_q.push_back({bus.st_addr, bus.st_data});
      exp_we_next   = !bus.mem_we && (m_count != 0);
      exp_idle_next = done;
      prev_we       = bus.mem_we;
      prev_done     = done;
      prev_bus      = {bus.mem_addr, bus.mem_data};
      m_count       = m_count + int'(accept) - int'(done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_valid = 1'b0;
    bus.st_data  = '0;
    bus.st_addr  = '0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [WS-1:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (!empty && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(empty), 64'd1);
  endtask

  task automatic wait_we(input string name, input int budget);
    int n = 0;
    while (!bus.mem_we && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(bus.mem_we), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    idle_inputs();
`ifdef STORE_FWD_EN
    ld_addr = '0;
`endif
    rst = 1'b0;
    tick();
    tick();
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_data", 64'(bus.mem_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(bus.st_ready), 64'd1);
    rst = 1'b1;
    tick();

    // 1: reset while a write is outstanding
    push_one(16'h0042, 24'h123456);
    wait_we("t1_we_timeout", 10);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t1_we", 64'(bus.mem_we), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_ready", 64'(bus.st_ready), 64'd1);
    tick();
    chk("t1_no_replay", 64'(bus.mem_we), 64'd0);

    // 2: single store, ack on the second WRITE cycle
    push_one(16'h0010, 24'h00ABCD);
    chk("t2_we_e0", 64'(bus.mem_we), 64'd0);
    tick();
    chk("t2_we_e1", 64'(bus.mem_we), 64'd1);
    chk("t2_addr_e1", 64'(bus.mem_addr), 64'h0010);
    chk("t2_data_e1", 64'(bus.mem_data), 64'h00ABCD);
    tick();
    chk("t2_we_e2", 64'(bus.mem_we), 64'd1);
    chk("t2_addr_e2", 64'(bus.mem_addr), 64'h0010);
    chk("t2_data_e2", 64'(bus.mem_data), 64'h00ABCD);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("t2_we_e3", 64'(bus.mem_we), 64'd0);
    chk("t2_empty", 64'(empty), 64'd1);

    // 3: five back-to-back stores with no ack
    for (int i = 0; i < 5; i++) begin
      bus.st_valid = 1'b1;
      bus.st_addr  = AW'(16'h0100 + i);
      bus.st_data  = WS'(i + 1);
      if (i == 4) chk("t3_ready_5th", 64'(bus.st_ready), 64'd0);
      tick();
    end
    bus.st_valid = 1'b0;
    chk("t3_count", 64'(count), 64'd4);

    // 4: drain with ack tied high
    base = n_done;
    bus.mem_ack = 1'b1;
    wait_empty("t4_drain_timeout", 20);
    bus.mem_ack = 1'b0;
    chk("t4_drained", 64'(n_done - base), 64'd4);

    // 5: full buffer, ack and push on the same edge
    for (int i = 0; i < 4; i++) push_one(AW'(16'h0200 + i), WS'(24'h00A000 + i));
    wait_we("t5_we_timeout", 5);
    bus.st_valid = 1'b1;
    bus.st_addr  = 16'h02FF;
    bus.st_data  = 24'h0000FF;
    bus.mem_ack  = 1'b1;
    chk("t5_ready_full", 64'(bus.st_ready), 64'd0);
    tick();
    bus.mem_ack = 1'b0;
    chk("t5_count_pop", 64'(count), 64'd3);
    tick();
    bus.st_valid = 1'b0;
    chk("t5_count_retry", 64'(count), 64'd4);
    bus.mem_ack = 1'b1;
    wait_empty("t5_drain_timeout", 20);
    bus.mem_ack = 1'b0;

`ifdef STORE_FWD_EN
    // 6: forwarding of the youngest matching store
    push_one(16'h0020, 24'h000001);
    push_one(16'h0020, 24'h000002);
    ld_addr = 16'h0020;
    #1;
    chk("t6_hit", 64'(fwd_hit), 64'd1);
    chk("t6_data", 64'(fwd_data), 64'h000002);
    ld_addr = 16'h0021;
    #1;
    chk("t6_miss_hit", 64'(fwd_hit), 64'd0);
    chk("t6_miss_data", 64'(fwd_data), 64'd0);
    bus.mem_ack = 1'b1;
    wait_empty("t6_drain_timeout", 20);
    bus.mem_ack = 1'b0;
`endif

    // Randomized traffic with a narrow address range so addresses repeat
    for (int c = 0; c < 400; c++) begin
      bus.st_valid = ($urandom_range(0, 2) != 0);
      bus.st_addr  = AW'($urandom_range(0, 7));
      bus.st_data  = WS'($urandom);
      bus.mem_ack  = ($urandom_range(0, 2) != 0);
`ifdef STORE_FWD_EN
      ld_addr = AW'($urandom_range(0, 7));
`endif
      tick();
    end
    bus.st_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    wait_empty("rand_drain_timeout", 40);
    bus.mem_ack = 1'b0;
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
